// File: rtl/seg_bcd_converter.sv
// seg_bcd_converter
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter feeding
// the four-digit seven-segment driver. A 16-bit unsigned value is accepted on
// VALID while idle. After a fixed 17-clock latency, four packed BCD digits
// appear on BCD together with a one-cycle DONE pulse.
// Values above 9999 cannot be shown in four decimal digits. For these values
// OVF is raised and a fixed pattern replaces the digits.
// Build option: define SEG_BCD_SATURATE_EN to clamp overflowed results to
// 16'h9999 instead of the default 16'hFFFF error pattern.

module seg_bcd_converter (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] BIN,
  input  logic        VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] BCD,
  output logic        OVF
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [15:0] MaxDecimal = 16'd9999;
  localparam logic [4:0]  LastIter   = 5'd15;

`ifdef SEG_BCD_SATURATE_EN
  localparam logic [15:0] OvfPattern = 16'h9999;
`else
  localparam logic [15:0] OvfPattern = 16'hFFFF;
`endif

  state_t      state_q, state_d;
  logic [4:0]  iterCnt_q, iterCnt_d;
  logic [15:0] shiftReg_q, shiftReg_d;
  logic [15:0] scratch_q, scratch_d;
  logic        ovfPending_q, ovfPending_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [15:0] adjusted;

  // A digit of 5 or more would exceed 9 after doubling, so add 3 before the shift.
  // Any carry out of the nibble is dropped; legal inputs never produce one.
  function automatic logic [3:0] addThree(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  // Correct all four scratch digits in parallel, using their pre-shift values.
  always_comb begin
    adjusted = {addThree(scratch_q[15:12]), addThree(scratch_q[11:8]),
                addThree(scratch_q[7:4]),   addThree(scratch_q[3:0])};
  end

  // Next-state and datapath control for IDLE -> CONV (16 iterations) -> FINISH.
  always_comb begin
    state_d      = state_q;
    iterCnt_d    = iterCnt_q;
    shiftReg_d   = shiftReg_q;
    scratch_d    = scratch_q;
    ovfPending_d = ovfPending_q;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (VALID) begin
          shiftReg_d   = BIN;
          scratch_d    = 16'h0000;
          ovfPending_d = (BIN > MaxDecimal);
          iterCnt_d    = 5'd0;
          state_d      = CONV;
        end
      end

      CONV: begin
        {scratch_d, shiftReg_d} = {adjusted, shiftReg_q} << 1;
        iterCnt_d = iterCnt_q + 5'd1;
        if (iterCnt_q == LastIter) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        bcd_d   = ovfPending_q ? OvfPattern : scratch_q;
        ovf_d   = ovfPending_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any conversion in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      iterCnt_q    <= 5'd0;
      shiftReg_q   <= 16'h0000;
      scratch_q    <= 16'h0000;
      ovfPending_q <= 1'b0;
      bcd_q        <= 16'h0000;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iterCnt_q    <= iterCnt_d;
      shiftReg_q   <= shiftReg_d;
      scratch_q    <= scratch_d;
      ovfPending_q <= ovfPending_d;
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign BCD  = bcd_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Testbench for seg_bcd_converter.
// A cycle-level reference model tracks the expected BUSY, DONE, BCD and OVF values.
// Expected results are pushed to a scoreboard queue when a value is accepted.
// They are popped on the edge where DONE is due.
// Every output is compared on every falling edge.

module tb_seg_bcd_converter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BIN;
  logic        VALID;
  logic        BUSY;
  logic        DONE;
  logic [15:0] BCD;
  logic        OVF;

  int checkCount = 0;
  int errCount   = 0;

  logic [16:0] expQ[$];
  int          rem     = 0;
  logic [15:0] expBcd  = 16'h0000;
  logic        expOvf  = 1'b0;
  logic        expDone = 1'b0;
  logic        monitorOn = 1'b0;

  seg_bcd_converter dut (
    .CLK   (CLK),
    .RST   (RST),
    .BIN   (BIN),
    .VALID (VALID),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD),
    .OVF   (OVF)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  // Decimal reference: {ovf, bcd} for a binary input
  function automatic logic [16:0] decimalModel(input logic [15:0] v);
    int n;
    logic [15:0] digits;
    n = int'(v);
    if (n > 9999) begin
`ifdef SEG_BCD_SATURATE_EN
      return {1'b1, 16'h9999};
`else
      return {1'b1, 16'hFFFF};
`endif
    end
    digits[15:12] = 4'(n / 1000);
    digits[11:8]  = 4'((n / 100) % 10);
    digits[7:4]   = 4'((n / 10) % 10);
    digits[3:0]   = 4'(n % 10);
    return {1'b0, digits};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  // Reference handshake model: 17 busy clocks per accepted value, then DONE
  always @(posedge CLK) begin
    logic idleNow;
    if (RST) begin
      rem     = 0;
      expBcd  = 16'h0000;
      expOvf  = 1'b0;
      expDone = 1'b0;
      expQ.delete();
    end else begin
      idleNow = (rem == 0);
      expDone = 1'b0;
      if (rem != 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          expDone = 1'b1;
          {expOvf, expBcd} = expQ.pop_front();
        end
      end
      if (idleNow && VALID) begin
        expQ.push_back(decimalModel(BIN));
        rem = 17;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge CLK) begin
    if (monitorOn) begin
      checkOutput("busy", 32'(BUSY), 32'(rem != 0));
      checkOutput("done", 32'(DONE), 32'(expDone));
      checkOutput("bcd",  32'(BCD),  32'(expBcd));
      checkOutput("ovf",  32'(OVF),  32'(expOvf));
    end
  end

  task automatic applyStimulus(input logic [15:0] value);
    BIN   = value;
    VALID = 1'b1;
    @(posedge CLK);
    #1;
    VALID = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < bound) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1'b1;
      n++;
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] edgeVals[12];

    RST   = 1'b1;
    VALID = 1'b0;
    BIN   = 16'h0000;
    monitorOn = 1'b1;
    idleCycles(2);
    RST = 1'b0;
    idleCycles(2);

    $display("[TB] basic conversion 1234");
    applyStimulus(16'd1234);
    waitDone(40);
    idleCycles(2);

    $display("[TB] back-to-back 0 then 9999");
    applyStimulus(16'd0);
    waitDone(40);
    applyStimulus(16'd9999);
    waitDone(40);
    idleCycles(2);

    $display("[TB] overflow inputs");
    applyStimulus(16'd10000);
    waitDone(40);
    applyStimulus(16'hFFFF);
    waitDone(40);
    idleCycles(2);

    $display("[TB] VALID and BIN changes while busy are ignored");
    applyStimulus(16'd42);
    for (int i = 0; i < 16; i++) begin
      BIN   = (i == 4) ? 16'd777 : 16'($urandom);
      VALID = (i == 4);
      @(posedge CLK);
      #1;
    end
    VALID = 1'b0;
    waitDone(10);
    idleCycles(25);

    $display("[TB] reset mid-conversion");
    applyStimulus(16'd5555);
    idleCycles(7);
    RST = 1'b1;
    idleCycles(1);
    RST = 1'b0;
    idleCycles(20);
    applyStimulus(16'd8);
    waitDone(40);
    idleCycles(2);

    $display("[TB] reset wins over VALID on the same edge");
    RST   = 1'b1;
    VALID = 1'b1;
    BIN   = 16'd321;
    idleCycles(1);
    RST   = 1'b0;
    VALID = 1'b0;
    idleCycles(3);

    $display("[TB] boundary values and strided sweep");
    edgeVals = '{16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999,
                 16'd1000, 16'd4999, 16'd5000, 16'd9998, 16'd9999, 16'd10001};
    foreach (edgeVals[k]) begin
      applyStimulus(edgeVals[k]);
      waitDone(40);
    end
    for (int v = 0; v <= 9999; v += 41) begin
      applyStimulus(16'(v));
      waitDone(40);
    end
    idleCycles(4);

    monitorOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
